mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Control stage wrapped around the team's 16:1 combinational mux (MUX_16x1).
- Accepts a 16-bit word over a valid/ready load interface and drives the word onto the mux `In` bus.
- Steps the mux `Sel` through all 16 indices and returns the mux `Y` output as a serial bitstream with a valid/ready handshake.
- Acts as the mux's upstream driver (`In`, `Sel`) and its downstream consumer (`Y`) in parallel-to-serial paths.

Parameters:
- WIDTH, 16, data word width; must equal the mux input width. Only 16 is supported.
- SEL_W, 4, select width; equals log2(WIDTH).
- MSB_FIRST, 0, bit order. 0: `Sel` steps 0→15 (LSB first). 1: `Sel` steps 15→0 (MSB first).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  `load_data` is valid.
- load_ready  output  1  block can accept a new word.
- load_data  input  WIDTH  word to serialize.
- mux_in  output  WIDTH  drives mux `In`; holds the latched word.
- mux_sel  output  SEL_W  drives mux `Sel`.
- mux_y  input  1  mux `Y` output, combinational from `mux_in`/`mux_sel`.
- ser_valid  output  1  `ser_data` is valid.
- ser_ready  input  1  consumer accepts `ser_data`.
- ser_data  output  1  current serial bit; equals `mux_y`.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is being serialized.

Behaviour:
- Reset (`rst_n` low, asynchronous): state=IDLE, mux_in=0, mux_sel=0, ser_valid=0, busy=0. `load_ready`=1 immediately after reset deasserts.
- States: IDLE and SHIFT. All outputs except `ser_data` come from registered state. `load_ready` = (state==IDLE). `busy` = (state==SHIFT).
- IDLE:
  - `ser_valid`=0.
  - On the rising edge where load_valid && load_ready:
    - mux_in <= load_data.
    - mux_sel <= 0 when MSB_FIRST=0, or 15 when MSB_FIRST=1.
    - ser_valid <= 1.
    - state <= SHIFT.
  - `load_data` is ignored when `load_valid` is low.
- SHIFT:
  - `ser_valid`=1.
  - `ser_data` = `mux_y`, a combinational pass-through with no added latency.
  - `ser_last`=1 when mux_sel==15 (MSB_FIRST=0) or mux_sel==0 (MSB_FIRST=1); otherwise 0.
  - On ser_valid && ser_ready, not last: mux_sel increments (MSB_FIRST=0) or decrements (MSB_FIRST=1) by 1.
  - On ser_valid && ser_ready, last: state <= IDLE, ser_valid <= 0. `mux_sel` keeps its final value and `mux_in` keeps the word.
- Backpressure: while `ser_ready` is low, `mux_sel`, `mux_in`, `ser_data` and `ser_last` hold stable and `ser_valid` stays 1. A handshaked bit is never skipped or repeated.
- Latency:
  - First serial bit is valid 1 cycle after the load handshake.
  - One word takes 16 accepted beats; with `ser_ready` held high that is 16 cycles.
  - One mandatory IDLE cycle separates consecutive words, so steady-state throughput is 16 bits per 17 cycles.
- `load_valid` while in SHIFT: `load_ready`=0 and the word is not accepted. The upstream holds `load_valid`/`load_data` (standard valid/ready).
- `ser_ready` in IDLE: ignored.
- Reset mid-word: the serialization is abandoned immediately and all outputs return to reset values. No partial word resumes after reset.
- `mux_sel` arithmetic: unsigned SEL_W bits. It never wraps during a word, because the last-bit check ends the word first.
- `ser_last` outside SHIFT: 0.

Test Plan:
1. Reset then load 16'h674F, MSB_FIRST=0, `ser_ready`=1 → ser_data over 16 beats = 1,1,1,1,0,0,1,0,1,1,1,0,0,1,1,0. Spot checks: sel=5 gives 0, sel=8 gives 1, sel=12 gives 0. `ser_last` is high only on beat 16. `load_ready` returns to 1 the cycle after beat 16.
2. MSB_FIRST=1, load 16'hA017 → bit sequence 1,0,1,0,0,0,0,0,0,0,0,1,0,1,1,1. `mux_sel` steps 15→0. At sel=0 the bit is 1 and `ser_last`=1.
3. Backpressure: load 16'h674F and deassert `ser_ready` for 3 cycles at sel=5 → `mux_sel` stays 5, ser_data=0 and ser_valid=1 throughout. The sequence then resumes with sel=6 (bit 1), and the full 16-bit sequence still matches scenario 1.
4. Back-to-back: hold load_valid=1 with 16'hFFFF then 16'h0000 → the second word is accepted only in the IDLE cycle after the first word's last beat. Output is 16 ones, one idle cycle with ser_valid=0, then 16 zeros.
5. Reset mid-word: assert `rst_n` low after beat 7 of 16'hA017 → ser_valid, mux_sel and mux_in go to 0 asynchronously and load_ready=1 after release. A new load of 16'h0001 then serializes cleanly as 1 followed by fifteen 0s (MSB_FIRST=0).

Source files
------------

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_sequencer
// Purpose  : Latches a 16-bit word onto a 16:1 mux and walks its select lines,
//            returning the mux output as a valid/ready serial bitstream.
// Revision : 1.0  initial release
// ============================================================================
module mux_sel_sequencer #(
    parameter int WIDTH     = 16,
    parameter int SEL_W     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_y,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Select index of the first and final bit of a word, by bit order.
    localparam logic [SEL_W-1:0] c_sel_first = (MSB_FIRST != 0) ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] c_sel_last  = (MSB_FIRST != 0) ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] c_sel_step  = {{(SEL_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mux_in;
    logic [WIDTH-1:0] w_mux_in_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_shift;
    logic             w_last;

    assign w_shift = (r_state == ST_SHIFT);
    assign w_last  = w_shift && (r_sel == c_sel_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mux_in <= '0;
            r_sel    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mux_in <= w_mux_in_nxt;
            r_sel    <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mux_in_nxt = r_mux_in;
        w_sel_nxt    = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_mux_in_nxt = load_data;
                    w_sel_nxt    = c_sel_first;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The word ends on the last bit, so the select never wraps.
                if (ser_ready) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (MSB_FIRST != 0) begin
                        w_sel_nxt = r_sel - c_sel_step;
                    end else begin
                        w_sel_nxt = r_sel + c_sel_step;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == ST_IDLE);
    assign busy       = w_shift;
    assign ser_valid  = w_shift;
    assign ser_last   = w_last;
    assign ser_data   = mux_y;
    assign mux_in     = r_mux_in;
    assign mux_sel    = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_sequencer
// Purpose  : Directed self-checking bench; LSB-first and MSB-first instances
//            each drive a behavioural 16:1 mux model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_sel_sequencer;

    logic        clk;
    logic        rst_n;

    logic        load_valid0, load_ready0, mux_y0, ser_valid0, ser_ready0;
    logic        ser_data0, ser_last0, busy0;
    logic [15:0] load_data0, mux_in0;
    logic [3:0]  mux_sel0;

    logic        load_valid1, load_ready1, mux_y1, ser_valid1, ser_ready1;
    logic        ser_data1, ser_last1, busy1;
    logic [15:0] load_data1, mux_in1;
    logic [3:0]  mux_sel1;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mux_sel_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid0), .load_ready(load_ready0), .load_data(load_data0),
        .mux_in(mux_in0), .mux_sel(mux_sel0), .mux_y(mux_y0),
        .ser_valid(ser_valid0), .ser_ready(ser_ready0), .ser_data(ser_data0),
        .ser_last(ser_last0), .busy(busy0)
    );

    mux_sel_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid1), .load_ready(load_ready1), .load_data(load_data1),
        .mux_in(mux_in1), .mux_sel(mux_sel1), .mux_y(mux_y1),
        .ser_valid(ser_valid1), .ser_ready(ser_ready1), .ser_data(ser_data1),
        .ser_last(ser_last1), .busy(busy1)
    );

    // Behavioural MUX_16x1 models.
    assign mux_y0 = mux_in0[mux_sel0];
    assign mux_y1 = mux_in1[mux_sel1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n       = 1'b0;
        load_valid0 = 1'b0; load_data0 = 16'h0; ser_ready0 = 1'b0;
        load_valid1 = 1'b0; load_data1 = 16'h0; ser_ready1 = 1'b0;
        #12;
        check_cnt++;
        if (mux_in0 !== 16'h0 || mux_sel0 !== 4'd0 || ser_valid0 !== 1'b0 || busy0 !== 1'b0 || ser_last0 !== 1'b0)
            $display("FAIL reset_lsb: in=%h sel=%0d valid=%b busy=%b last=%b, want 0000/0/0/0/0",
                     mux_in0, mux_sel0, ser_valid0, busy0, ser_last0);
        else pass_cnt++;
        check_cnt++;
        if (mux_in1 !== 16'h0 || mux_sel1 !== 4'd0 || ser_valid1 !== 1'b0 || busy1 !== 1'b0 || ser_last1 !== 1'b0)
            $display("FAIL reset_msb: in=%h sel=%0d valid=%b busy=%b last=%b, want 0000/0/0/0/0",
                     mux_in1, mux_sel1, ser_valid1, busy1, ser_last1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (load_ready0 !== 1'b1 || load_ready1 !== 1'b1)
            $display("FAIL reset_load_ready: got %b/%b, want 1/1", load_ready0, load_ready1);
        else pass_cnt++;
    endtask

    // Beat i of the expected stream is exp[15-i].
    task automatic run_lsb_word(input logic [15:0] word, input logic [15:0] exp, input string name);
        @(negedge clk);
        load_valid0 = 1'b1; load_data0 = word; ser_ready0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid0 = 1'b0;
            check_cnt++;
            if (ser_valid0 !== 1'b1 || ser_data0 !== exp[15-i] || mux_sel0 !== 4'(i) ||
                ser_last0 !== (i == 15) || load_ready0 !== 1'b0)
                $display("FAIL %s beat%0d: valid=%b data=%b sel=%0d last=%b lrdy=%b, want 1/%b/%0d/%b/0",
                         name, i, ser_valid0, ser_data0, mux_sel0, ser_last0, load_ready0,
                         exp[15-i], i, (i == 15));
            else pass_cnt++;
        end
        @(negedge clk);
        check_cnt++;
        if (ser_valid0 !== 1'b0 || load_ready0 !== 1'b1 || ser_last0 !== 1'b0 || mux_sel0 !== 4'd15 || mux_in0 !== word)
            $display("FAIL %s end: valid=%b lrdy=%b last=%b sel=%0d in=%h, want 0/1/0/15/%h",
                     name, ser_valid0, load_ready0, ser_last0, mux_sel0, mux_in0, word);
        else pass_cnt++;
    endtask

    task automatic test_lsb_first;
        run_lsb_word(16'h674F, 16'b1111_0010_1110_0110, "lsb_674F");
    endtask

    task automatic test_msb_first;
        logic [15:0] exp;
        exp = 16'b1010_0000_0001_0111;
        @(negedge clk);
        load_valid1 = 1'b1; load_data1 = 16'hA017; ser_ready1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid1 = 1'b0;
            check_cnt++;
            if (ser_valid1 !== 1'b1 || ser_data1 !== exp[15-i] || mux_sel1 !== 4'(15 - i) || ser_last1 !== (i == 15))
                $display("FAIL msb_A017 beat%0d: valid=%b data=%b sel=%0d last=%b, want 1/%b/%0d/%b",
                         i, ser_valid1, ser_data1, mux_sel1, ser_last1, exp[15-i], 15 - i, (i == 15));
            else pass_cnt++;
        end
        @(negedge clk);
        check_cnt++;
        if (ser_valid1 !== 1'b0 || load_ready1 !== 1'b1 || mux_sel1 !== 4'd0)
            $display("FAIL msb_end: valid=%b lrdy=%b sel=%0d, want 0/1/0", ser_valid1, load_ready1, mux_sel1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic [15:0] exp;
        exp = 16'b1111_0010_1110_0110;
        @(negedge clk);
        load_valid0 = 1'b1; load_data0 = 16'h674F; ser_ready0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid0 = 1'b0;
            check_cnt++;
            if (ser_valid0 !== 1'b1 || ser_data0 !== exp[15-i] || mux_sel0 !== 4'(i) || ser_last0 !== (i == 15))
                $display("FAIL bp beat%0d: valid=%b data=%b sel=%0d last=%b, want 1/%b/%0d/%b",
                         i, ser_valid0, ser_data0, mux_sel0, ser_last0, exp[15-i], i, (i == 15));
            else pass_cnt++;
            if (i == 5) begin
                ser_ready0 = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check_cnt++;
                    if (mux_sel0 !== 4'd5 || ser_data0 !== 1'b0 || ser_valid0 !== 1'b1 || ser_last0 !== 1'b0 || mux_in0 !== 16'h674F)
                        $display("FAIL bp stall%0d: sel=%0d data=%b valid=%b last=%b in=%h, want 5/0/1/0/674f",
                                 s, mux_sel0, ser_data0, ser_valid0, ser_last0, mux_in0);
                    else pass_cnt++;
                end
                ser_ready0 = 1'b1;
            end
        end
        @(negedge clk);
        check_cnt++;
        if (ser_valid0 !== 1'b0 || load_ready0 !== 1'b1)
            $display("FAIL bp end: valid=%b lrdy=%b, want 0/1", ser_valid0, load_ready0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        load_valid0 = 1'b1; load_data0 = 16'hFFFF; ser_ready0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_data0 = 16'h0000;
            check_cnt++;
            if (ser_valid0 !== 1'b1 || ser_data0 !== 1'b1 || load_ready0 !== 1'b0 || mux_in0 !== 16'hFFFF)
                $display("FAIL b2b w1 beat%0d: valid=%b data=%b lrdy=%b in=%h, want 1/1/0/ffff",
                         i, ser_valid0, ser_data0, load_ready0, mux_in0);
            else pass_cnt++;
        end
        @(negedge clk);
        check_cnt++;
        if (ser_valid0 !== 1'b0 || load_ready0 !== 1'b1)
            $display("FAIL b2b gap: valid=%b lrdy=%b, want 0/1", ser_valid0, load_ready0);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid0 = 1'b0;
            check_cnt++;
            if (ser_valid0 !== 1'b1 || ser_data0 !== 1'b0 || mux_sel0 !== 4'(i) || mux_in0 !== 16'h0000)
                $display("FAIL b2b w2 beat%0d: valid=%b data=%b sel=%0d in=%h, want 1/0/%0d/0000",
                         i, ser_valid0, ser_data0, mux_sel0, mux_in0, i);
            else pass_cnt++;
        end
        @(negedge clk);
        check_cnt++;
        if (ser_valid0 !== 1'b0 || load_ready0 !== 1'b1)
            $display("FAIL b2b end: valid=%b lrdy=%b, want 0/1", ser_valid0, load_ready0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word;
        logic [15:0] exp;
        exp = 16'b1110_1000_0000_0101; // 16'hA017 sent LSB first
        @(negedge clk);
        load_valid0 = 1'b1; load_data0 = 16'hA017; ser_ready0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            load_valid0 = 1'b0;
            check_cnt++;
            if (ser_valid0 !== 1'b1 || ser_data0 !== exp[15-i] || mux_sel0 !== 4'(i))
                $display("FAIL rmid beat%0d: valid=%b data=%b sel=%0d, want 1/%b/%0d",
                         i, ser_valid0, ser_data0, mux_sel0, exp[15-i], i);
            else pass_cnt++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (ser_valid0 !== 1'b0 || mux_sel0 !== 4'd0 || mux_in0 !== 16'h0 || busy0 !== 1'b0)
            $display("FAIL rmid async: valid=%b sel=%0d in=%h busy=%b, want 0/0/0000/0",
                     ser_valid0, mux_sel0, mux_in0, busy0);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (load_ready0 !== 1'b1 || ser_valid0 !== 1'b0)
            $display("FAIL rmid release: lrdy=%b valid=%b, want 1/0", load_ready0, ser_valid0);
        else pass_cnt++;
        run_lsb_word(16'h0001, 16'b1000_0000_0000_0000, "rmid_0001");
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
